triangle_area_unit: RTL and testbench

- Pipelined stage directly upstream of the face culler in the triangle pipe.
- Accepts a screen-space triangle (three vertices) per beat and computes twice the signed area: (xb−xa)(yc−ya) − (xc−xa)(yb−ya).
- Emits areaSign, a zero-area flag and the unchanged vertices so the culler consumes vertices and sign in the same beat.
- Valid/ready on both sides; sustains one triangle per clock.

---
 rtl/triangle_pipe_pkg.sv | 66 ++++++
 rtl/pipe_stage_reg.sv | 43 ++++
 rtl/triangle_area_unit.sv | 144 ++++++++++++++
 tb/tb_triangle_area_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_pipe_pkg.sv
// ---------------------------------------------------------------------------
// triangle_pipe_pkg
// Shared definitions for the triangle pipe: coordinate and vertex widths,
// vertex field slices, the areaSign encoding shared with the face culler,
// the doubled-area width, and the per-stage payload structs used by
// triangle_area_unit.
// A vertex is packed {x, y, z} with x in the MSBs; each coordinate is a
// signed two's-complement value of COORD_W bits.
// ---------------------------------------------------------------------------
package triangle_pipe_pkg;

    localparam int COORD_W = 22;
    localparam int VERT_W  = 3 * COORD_W;
    localparam int AREA_W  = 2 * COORD_W + 3;

    // Edge deltas need one extra bit, products of two deltas need double that.
    localparam int DIFF_W  = COORD_W + 1;
    localparam int PROD_W  = 2 * COORD_W + 2;

    localparam int X_MSB = VERT_W - 1;
    localparam int X_LSB = 2 * COORD_W;
    localparam int Y_MSB = 2 * COORD_W - 1;
    localparam int Y_LSB = COORD_W;
    localparam int Z_MSB = COORD_W - 1;
    localparam int Z_LSB = 0;

    typedef enum logic {
        PLUS  = 1'b0,
        MINUS = 1'b1
    } area_sign_e;

    typedef logic [VERT_W-1:0] vertex_t;

    typedef struct packed {
        vertex_t           pa;
        vertex_t           pb;
        vertex_t           pc;
        logic [DIFF_W-1:0] dx1;
        logic [DIFF_W-1:0] dy1;
        logic [DIFF_W-1:0] dx2;
        logic [DIFF_W-1:0] dy2;
    } s1_t;

    typedef struct packed {
        vertex_t           pa;
        vertex_t           pb;
        vertex_t           pc;
        logic [PROD_W-1:0] p1;
        logic [PROD_W-1:0] p2;
    } s2_t;

    typedef struct packed {
        vertex_t           pa;
        vertex_t           pb;
        vertex_t           pc;
        logic [AREA_W-1:0] area;
        area_sign_e        sign;
        logic              degenerate;
    } s3_t;

    // Sign-extends an edge delta to product width so the multiply is exact.
    function automatic logic [PROD_W-1:0] sext_diff(input logic [DIFF_W-1:0] d);
        return {{(PROD_W - DIFF_W){d[DIFF_W-1]}}, d};
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// One valid/data pipeline register with elastic advance.
// The slot accepts new contents whenever it is empty or its downstream
// neighbour advances, so bubbles collapse under backpressure.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   up_valid        upstream slot holds data
//   up_data         upstream payload (W bits)
//   down_advance    downstream slot will accept this cycle
//   valid, data     registered slot contents
//   advance         this slot will accept from upstream this cycle
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         down_advance,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         advance
);

    assign advance = !valid || down_advance;

    // Payload only loads with a real item, so a bubble leaves the old data in
    // place and a stalled slot never changes what it presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (advance) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/triangle_area_unit.sv
// ---------------------------------------------------------------------------
// triangle_area_unit
// Three-stage pipeline computing twice the signed screen-space area of a
// triangle: (xb-xa)(yc-ya) - (xc-xa)(yb-ya). Vertices ride along unchanged
// so the downstream culler sees vertices and sign in the same beat.
//   S1: edge deltas, S2: cross products, S3: difference, sign, zero test.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           input handshake
//   in_Pa, in_Pb, in_Pc         input vertices {x, y, z}
//   out_valid/out_ready         output handshake
//   out_Pa, out_Pb, out_Pc      vertices passed through
//   out_area                    signed doubled area (AREA_W bits)
//   out_areaSign                PLUS (area >= 0) or MINUS (area < 0)
//   out_degenerate              area == 0
// Optional build macro TRI_AREA_DROP_DEGENERATE_EN: zero-area triangles are
// silently consumed in S3 and out_degenerate is tied low.
// ---------------------------------------------------------------------------
module triangle_area_unit
    import triangle_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VERT_W-1:0] in_Pa,
    input  logic [VERT_W-1:0] in_Pb,
    input  logic [VERT_W-1:0] in_Pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VERT_W-1:0] out_Pa,
    output logic [VERT_W-1:0] out_Pb,
    output logic [VERT_W-1:0] out_Pc,
    output logic [AREA_W-1:0] out_area,
    output logic              out_areaSign,
    output logic              out_degenerate
);

    logic [COORD_W-1:0] xa, ya, xb, yb, xc, yc;
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    logic v1, v2, v3;
    logic adv1, adv2, adv3, adv4;
    logic drop_now;
    logic [AREA_W-1:0] s3_area;

    assign xa = in_Pa[X_MSB:X_LSB];
    assign ya = in_Pa[Y_MSB:Y_LSB];
    assign xb = in_Pb[X_MSB:X_LSB];
    assign yb = in_Pb[Y_MSB:Y_LSB];
    assign xc = in_Pc[X_MSB:X_LSB];
    assign yc = in_Pc[Y_MSB:Y_LSB];

    // S1 input: deltas are formed one bit wider so they cannot wrap.
    always_comb begin
        s1_d     = '0;
        s1_d.pa  = in_Pa;
        s1_d.pb  = in_Pb;
        s1_d.pc  = in_Pc;
        s1_d.dx1 = {xb[COORD_W-1], xb} - {xa[COORD_W-1], xa};
        s1_d.dy1 = {yb[COORD_W-1], yb} - {ya[COORD_W-1], ya};
        s1_d.dx2 = {xc[COORD_W-1], xc} - {xa[COORD_W-1], xa};
        s1_d.dy2 = {yc[COORD_W-1], yc} - {ya[COORD_W-1], ya};
    end

    // S2 input: operands are sign-extended to full product width first, so
    // the truncated PROD_W-bit product equals the exact signed product.
    always_comb begin
        s2_d    = '0;
        s2_d.pa = s1_q.pa;
        s2_d.pb = s1_q.pb;
        s2_d.pc = s1_q.pc;
        s2_d.p1 = sext_diff(s1_q.dx1) * sext_diff(s1_q.dy2);
        s2_d.p2 = sext_diff(s1_q.dx2) * sext_diff(s1_q.dy1);
    end

    assign s3_area = {s2_q.p1[PROD_W-1], s2_q.p1} - {s2_q.p2[PROD_W-1], s2_q.p2};

    // S3 input: zero area has a clear MSB and therefore reports PLUS.
    always_comb begin
        s3_d            = '0;
        s3_d.pa         = s2_q.pa;
        s3_d.pb         = s2_q.pb;
        s3_d.pc         = s2_q.pc;
        s3_d.area       = s3_area;
        s3_d.sign       = s3_area[AREA_W-1] ? MINUS : PLUS;
        s3_d.degenerate = (s3_area == '0);
    end

`ifdef TRI_AREA_DROP_DEGENERATE_EN
    // A degenerate triangle in S3 is never presented; its slot frees at once.
    assign drop_now       = v3 && s3_q.degenerate;
    assign out_valid      = v3 && !s3_q.degenerate;
    assign out_degenerate = 1'b0;
`else
    assign drop_now       = 1'b0;
    assign out_valid      = v3;
    assign out_degenerate = s3_q.degenerate;
`endif

    assign adv4     = out_ready || drop_now;
    assign in_ready = adv1;

    pipe_stage_reg #(.W($bits(s1_t))) u_stage1 (
        .clk          (clk),
        .rst          (rst),
        .up_valid     (in_valid),
        .up_data      (s1_d),
        .down_advance (adv2),
        .valid        (v1),
        .data         (s1_q),
        .advance      (adv1)
    );

    pipe_stage_reg #(.W($bits(s2_t))) u_stage2 (
        .clk          (clk),
        .rst          (rst),
        .up_valid     (v1),
        .up_data      (s2_d),
        .down_advance (adv3),
        .valid        (v2),
        .data         (s2_q),
        .advance      (adv2)
    );

    pipe_stage_reg #(.W($bits(s3_t))) u_stage3 (
        .clk          (clk),
        .rst          (rst),
        .up_valid     (v2),
        .up_data      (s3_d),
        .down_advance (adv4),
        .valid        (v3),
        .data         (s3_q),
        .advance      (adv3)
    );

    assign out_Pa       = s3_q.pa;
    assign out_Pb       = s3_q.pb;
    assign out_Pc       = s3_q.pc;
    assign out_area     = s3_q.area;
    assign out_areaSign = s3_q.sign;

endmodule

// File: tb/tb_triangle_area_unit.sv
// ---------------------------------------------------------------------------
// tb_triangle_area_unit
// Scoreboard bench for triangle_area_unit. The driver pushes the expected
// result of every accepted triangle into a queue; an independent monitor
// pops and compares whenever the unit hands a triangle downstream, and
// also checks that a stalled output holds its values.
// ---------------------------------------------------------------------------
module tb_triangle_area_unit;
    import triangle_pipe_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [VERT_W-1:0] in_Pa, in_Pb, in_Pc;
    logic              out_valid;
    logic              out_ready;
    logic [VERT_W-1:0] out_Pa, out_Pb, out_Pc;
    logic [AREA_W-1:0] out_area;
    logic              out_areaSign;
    logic              out_degenerate;

    typedef struct {
        logic [VERT_W-1:0] pa, pb, pc;
        logic [AREA_W-1:0] area;
        logic              sign;
        logic              deg;
        int                t_in;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    int   retries = 0;
    bit   check_latency = 0;

    triangle_area_unit dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_Pa          (in_Pa),
        .in_Pb          (in_Pb),
        .in_Pc          (in_Pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_Pa         (out_Pa),
        .out_Pb         (out_Pb),
        .out_Pc         (out_Pc),
        .out_area       (out_area),
        .out_areaSign   (out_areaSign),
        .out_degenerate (out_degenerate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VERT_W-1:0] mk(input int x, input int y, input int z);
        logic [COORD_W-1:0] cx, cy, cz;
        cx = x[COORD_W-1:0];
        cy = y[COORD_W-1:0];
        cz = z[COORD_W-1:0];
        return {cx, cy, cz};
    endfunction

    function automatic longint cx_of(input logic [VERT_W-1:0] v);
        logic signed [COORD_W-1:0] c;
        c = v[VERT_W-1 -: COORD_W];
        return longint'(c);
    endfunction

    function automatic longint cy_of(input logic [VERT_W-1:0] v);
        logic signed [COORD_W-1:0] c;
        c = v[2*COORD_W-1 -: COORD_W];
        return longint'(c);
    endfunction

    // Reference: plain integer cross product of the two edges from Pa.
    function automatic exp_t model(input logic [VERT_W-1:0] pa, pb, pc);
        exp_t   e;
        longint a;
        a = (cx_of(pb) - cx_of(pa)) * (cy_of(pc) - cy_of(pa))
          - (cx_of(pc) - cx_of(pa)) * (cy_of(pb) - cy_of(pa));
        e.pa   = pa;
        e.pb   = pb;
        e.pc   = pc;
        e.area = a[AREA_W-1:0];
        e.sign = (a < 0);
        e.deg  = (a == 0);
        e.t_in = cyc;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [VERT_W-1:0] act,
                               input logic [VERT_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Call right after a falling edge; returns on the falling edge after the
    // triangle has been accepted.
    task automatic applyStimulus(input logic [VERT_W-1:0] pa, pb, pc);
        exp_t e;
        int   n = 0;
        in_valid = 1'b1;
        in_Pa = pa;
        in_Pb = pb;
        in_Pc = pc;
        forever begin
            #2;
            if (in_ready) begin
                e = model(pa, pb, pc);
`ifdef TRI_AREA_DROP_DEGENERATE_EN
                if (!e.deg) sb.push_back(e);
`else
                sb.push_back(e);
`endif
                @(negedge clk);
                break;
            end
            n++;
            retries++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL input_accept_timeout actual=stalled required=accepted");
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic randomTriangle(input bit allow_gap);
        logic [VERT_W-1:0] pa, pb, pc;
        int sel;
        pa = {$urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom};
        pc = {$urandom, $urandom, $urandom};
        sel = $urandom_range(0, 9);
        if (sel == 0) pc = pa;
        else if (sel == 1) pb = mk(int'($urandom_range(0, 99)), 7, 1);
        else if (sel == 2) begin
            pa = mk(3, 3, 0);
            pb = mk(6, 6, 1);
            pc = mk(-9, -9, 2);
        end
        if (allow_gap && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        applyStimulus(pa, pb, pc);
    endtask

    // Downstream ready pattern: 0 always, 1 repeating 1,0,0, 2 random, 3 never.
    initial begin : ready_driver
        int phase = 0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every transfer against the scoreboard head.
    initial begin : monitor
        exp_t e;
        bit held = 0;
        logic [VERT_W-1:0] h_pa, h_pc;
        logic [AREA_W-1:0] h_area;
        logic h_sign, h_deg;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 0;
                continue;
            end
            if (held) begin
                checkOutput("hold_valid", VERT_W'(out_valid), VERT_W'(1));
                checkOutput("hold_area", VERT_W'(out_area), VERT_W'(h_area));
                checkOutput("hold_pa", out_Pa, h_pa);
                checkOutput("hold_pc", out_Pc, h_pc);
                checkOutput("hold_flags", VERT_W'({out_areaSign, out_degenerate}),
                            VERT_W'({h_sign, h_deg}));
            end
            held = 0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output actual=area %0h required=none", out_area);
                end else begin
                    e = sb.pop_front();
                    checkOutput("area", VERT_W'(out_area), VERT_W'(e.area));
                    checkOutput("areaSign", VERT_W'(out_areaSign), VERT_W'(e.sign));
`ifdef TRI_AREA_DROP_DEGENERATE_EN
                    checkOutput("degenerate", VERT_W'(out_degenerate), VERT_W'(0));
`else
                    checkOutput("degenerate", VERT_W'(out_degenerate), VERT_W'(e.deg));
`endif
                    checkOutput("Pa", out_Pa, e.pa);
                    checkOutput("Pb", out_Pb, e.pb);
                    checkOutput("Pc", out_Pc, e.pc);
                    if (check_latency)
                        checkOutput("latency", VERT_W'(cyc - e.t_in), VERT_W'(3));
                end
            end else if (out_valid) begin
                held = 1;
                h_pa = out_Pa;
                h_pc = out_Pc;
                h_area = out_area;
                h_sign = out_areaSign;
                h_deg = out_degenerate;
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, VERT_W'(out_valid), VERT_W'(0));
        checkOutput({tag, "_out_area"}, VERT_W'(out_area), VERT_W'(0));
        checkOutput({tag, "_flags"}, VERT_W'({out_areaSign, out_degenerate}), VERT_W'(0));
        checkOutput({tag, "_out_Pa"}, out_Pa, VERT_W'(0));
        checkOutput({tag, "_in_ready"}, VERT_W'(in_ready), VERT_W'(1));
    endtask

    initial begin : main
        int lim;
        rst = 1'b1;
        in_valid = 1'b0;
        in_Pa = '0;
        in_Pb = '0;
        in_Pc = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        checkResetState("reset");
        $display("[TB] reset released");

        // Directed triangles, each draining before the next.
        check_latency = 1;
        @(negedge clk);
        applyStimulus(mk(0, 0, 5), mk(4, 0, 6), mk(0, 4, 7));
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(mk(0, 0, 5), mk(0, 4, 7), mk(4, 0, 6));
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(mk(0, 0, 0), mk(2, 2, 0), mk(5, 5, 0));
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(mk(-(1 << 21), -(1 << 21), 123), mk((1 << 21) - 1, -(1 << 21), -1),
                      mk(-(1 << 21), (1 << 21) - 1, 0));
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_latency = 0;

        // Eight back-to-back triangles under 1,0,0 backpressure.
        $display("[TB] backpressure stream");
        ready_mode = 1;
        for (int i = 0; i < 8; i++)
            applyStimulus(mk(i, -i, i), mk(10 * i + 3, 2, 0), mk(-5, 7 * i + 1, 9));
        in_valid = 1'b0;

        // Random traffic with random readiness and input gaps.
        $display("[TB] random stream");
        ready_mode = 2;
        for (int i = 0; i < 60; i++) randomTriangle(1'b1);
        in_valid = 1'b0;

        // Reset with three triangles stuck in the pipe.
        $display("[TB] mid-flight reset");
        ready_mode = 3;
        repeat (8) @(negedge clk);
        ready_mode = 0;
        lim = 0;
        while (sb.size() != 0 && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        ready_mode = 3;
        repeat (2) @(negedge clk);
        applyStimulus(mk(1, 1, 1), mk(9, 1, 1), mk(1, 9, 1));
        applyStimulus(mk(2, 2, 2), mk(2, 9, 2), mk(9, 2, 2));
        applyStimulus(mk(0, 0, 0), mk(50, 0, 0), mk(0, 50, 0));
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 0;
        #2;
        checkResetState("midreset");
        @(negedge clk);
        for (int i = 0; i < 20; i++) randomTriangle(1'b0);
        in_valid = 1'b0;

        // Full throughput with the output always ready.
        ready_mode = 0;
        repeat (6) @(negedge clk);
        retries = 0;
        for (int i = 0; i < 12; i++) randomTriangle(1'b0);
        in_valid = 1'b0;
        checkOutput("throughput_stalls", VERT_W'(retries), VERT_W'(0));

        lim = 0;
        while (sb.size() != 0 && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout actual=%0d pending required=0", sb.size());
        end
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
